// File: rtl/lcd_bl_ctrl.sv
// Front-panel button debounce, activity tracking and LCD backlight idle-timeout FSM.
// Define LCD_BL_FADE_EN to include the PWM fade-out stage between ON and DARK.
module lcd_bl_ctrl #(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int N_BTN       = 2,
    parameter int DEBOUNCE_MS = 20,
    parameter int MS_W        = 15,
    parameter int PWM_W       = 8
) (
    input  logic             clk27,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             remote_event,
    input  logic             bl_enable,
    input  logic             force_on,
    input  logic [MS_W-1:0]  timeout_ms,
    input  logic [3:0]       fade_step_ms,
    output logic [N_BTN-1:0] btn_out,
    output logic [N_BTN-1:0] btn_press,
    output logic             bl_pwm,
    output logic [1:0]       bl_state,
    output logic [MS_W-1:0]  idle_ms
);
    localparam int MS_DIV = CLK_FREQ_HZ / 1000;
    localparam int PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int DB_W   = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_MS);

    logic [PRE_W-1:0] db_pre_q;
    logic             db_tick;

    assign db_tick = (db_pre_q == PRE_LAST);

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) db_pre_q <= '0;
        else          db_pre_q <= db_tick ? '0 : db_pre_q + 1'b1;
    end

    logic [N_BTN-1:0] sync1_q, sync2_q, btn_lvl, btn_out_q, btn_press_q;
    logic [DB_W-1:0]  db_cnt_q [N_BTN];

    // Buttons are active-low on the pins; btn_lvl is 1 while pressed.
    assign btn_lvl = ~sync2_q;

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            btn_out_q   <= '0;
            btn_press_q <= '0;
            for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q     <= btn_in;
            sync2_q     <= sync1_q;
            btn_press_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                if (btn_lvl[i] == btn_out_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_tick) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_cnt_q[i]    <= '0;
                        btn_out_q[i]   <= btn_lvl[i];
                        btn_press_q[i] <= btn_lvl[i];
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    logic rem_sync1_q, rem_sync2_q, rem_prev_q;
    logic activity;

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            rem_sync1_q <= 1'b0;
            rem_sync2_q <= 1'b0;
            rem_prev_q  <= 1'b0;
        end else begin
            rem_sync1_q <= remote_event;
            rem_sync2_q <= rem_sync1_q;
            rem_prev_q  <= rem_sync2_q;
        end
    end

    assign activity = (rem_sync2_q != rem_prev_q) | (|btn_press_q);

    logic [PRE_W-1:0] idle_pre_q, idle_pre_d;
    logic [MS_W-1:0]  idle_ms_q, idle_ms_d;

    always_comb begin
        idle_pre_d = idle_pre_q;
        idle_ms_d  = idle_ms_q;
        if (activity) begin
            idle_pre_d = '0;
            idle_ms_d  = '0;
        end else if (idle_pre_q == PRE_LAST) begin
            idle_pre_d = '0;
            if (idle_ms_q != '1) idle_ms_d = idle_ms_q + 1'b1;
        end else begin
            idle_pre_d = idle_pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            idle_pre_q <= '0;
            idle_ms_q  <= '0;
        end else begin
            idle_pre_q <= idle_pre_d;
            idle_ms_q  <= idle_ms_d;
        end
    end

    logic timeout_hit;
    assign timeout_hit = (timeout_ms != '0) && (idle_ms_q >= timeout_ms) && !force_on && !activity;

`ifdef LCD_BL_FADE_EN
    typedef enum logic [1:0] {ST_OFF = 2'b00, ST_ON = 2'b01, ST_FADE = 2'b10, ST_DARK = 2'b11} bl_state_e;

    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    bl_state_e        state_q;
    logic             bl_pwm_q;
    logic [PWM_W-1:0] duty_q, pwm_cnt_q;
    logic [PRE_W-1:0] fade_pre_q;
    logic [3:0]       fade_ms_q;
    logic             fade_step;

    // The fade ms counter restarts on FADE entry so the first step is a full period.
    assign fade_step = (fade_pre_q == PRE_LAST) &&
                       (({1'b0, fade_ms_q} + 5'd1) >= {1'b0, fade_step_ms});

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_OFF;
            bl_pwm_q   <= 1'b0;
            duty_q     <= '0;
            pwm_cnt_q  <= '0;
            fade_pre_q <= '0;
            fade_ms_q  <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (fade_pre_q == PRE_LAST) begin
                fade_pre_q <= '0;
                fade_ms_q  <= fade_step ? '0 : fade_ms_q + 1'b1;
            end else begin
                fade_pre_q <= fade_pre_q + 1'b1;
            end

            if (!bl_enable) begin
                state_q  <= ST_OFF;
                bl_pwm_q <= 1'b0;
                duty_q   <= '0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        state_q  <= ST_ON;
                        bl_pwm_q <= 1'b1;
                    end
                    ST_ON: begin
                        if (timeout_hit) begin
                            if (fade_step_ms != 4'd0) begin
                                state_q    <= ST_FADE;
                                duty_q     <= DUTY_MAX;
                                fade_pre_q <= '0;
                                fade_ms_q  <= '0;
                                bl_pwm_q   <= (pwm_cnt_q < DUTY_MAX);
                            end else begin
                                state_q  <= ST_DARK;
                                bl_pwm_q <= 1'b0;
                            end
                        end else begin
                            bl_pwm_q <= 1'b1;
                        end
                    end
                    ST_FADE: begin
                        if (activity || force_on) begin
                            state_q  <= ST_ON;
                            bl_pwm_q <= 1'b1;
                            duty_q   <= '0;
                        end else if (fade_step) begin
                            if (duty_q == '0) begin
                                state_q  <= ST_DARK;
                                bl_pwm_q <= 1'b0;
                            end else begin
                                duty_q   <= duty_q - 1'b1;
                                bl_pwm_q <= (pwm_cnt_q < (duty_q - 1'b1));
                            end
                        end else begin
                            bl_pwm_q <= (pwm_cnt_q < duty_q);
                        end
                    end
                    default: begin
                        if (activity || force_on) begin
                            state_q  <= ST_ON;
                            bl_pwm_q <= 1'b1;
                        end else begin
                            bl_pwm_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
`else
    typedef enum logic [1:0] {ST_OFF = 2'b00, ST_ON = 2'b01, ST_DARK = 2'b11} bl_state_e;

    bl_state_e state_q;
    logic      bl_pwm_q;
    logic      unused_nofade;

    assign unused_nofade = ^{fade_step_ms, {PWM_W{1'b0}}};

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_OFF;
            bl_pwm_q <= 1'b0;
        end else if (!bl_enable) begin
            state_q  <= ST_OFF;
            bl_pwm_q <= 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_q  <= ST_ON;
                    bl_pwm_q <= 1'b1;
                end
                ST_ON: begin
                    if (timeout_hit) begin
                        state_q  <= ST_DARK;
                        bl_pwm_q <= 1'b0;
                    end else begin
                        bl_pwm_q <= 1'b1;
                    end
                end
                default: begin
                    if (activity || force_on) begin
                        state_q  <= ST_ON;
                        bl_pwm_q <= 1'b1;
                    end else begin
                        bl_pwm_q <= 1'b0;
                    end
                end
            endcase
        end
    end
`endif

    assign btn_out   = btn_out_q;
    assign btn_press = btn_press_q;
    assign bl_pwm    = bl_pwm_q;
    assign bl_state  = state_q;
    assign idle_ms   = idle_ms_q;

endmodule

// File: doc/lcd_bl_ctrl.md
# lcd_bl_ctrl

Parametrised front-panel activity and LCD backlight controller in the clk27 domain, next to the CPU subsystem. It synchronises and debounces N front-panel buttons and tracks user activity from the buttons and the CPU remote-event toggle. It drives the LCD backlight through an idle-timeout state machine with a PWM fade-out. It replaces fixed 3/10/30 s backlight timeout codes with a millisecond timeout register, and replaces raw 2-FF button sampling with debounced levels and press pulses.

## Interface
Parameters:
- CLK_FREQ_HZ, 27000000, clock frequency; ms prescaler period = CLK_FREQ_HZ/1000.
- N_BTN, 2, number of buttons.
- DEBOUNCE_MS, 20, stable time required before a button level change is accepted.
- MS_W, 15, width of the ms counters and timeout.
- PWM_W, 8, PWM duty resolution.

Ports:
- clk27  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_in  in  N_BTN  raw asynchronous buttons, active-low.
- remote_event  in  1  CPU activity toggle; each level change is one event.
- bl_enable  in  1  backlight master enable.
- force_on  in  1  hold backlight on; no timeout (latency tester active).
- timeout_ms  in  MS_W  idle timeout in ms; 0 = never time out.
- fade_step_ms  in  4  ms per duty decrement; 0 = no fade.
- btn_out  out  N_BTN  debounced level, 1 = pressed.
- btn_press  out  N_BTN  one-cycle pulse on each debounced press.
- bl_pwm  out  1  backlight drive.
- bl_state  out  2  00 OFF, 01 ON, 10 FADE, 11 DARK.
- idle_ms  out  MS_W  ms since last activity; saturates at all-ones.

## Operation
- Reset values: btn_out=0, btn_press=0, bl_pwm=0, bl_state=OFF, idle_ms=0, duty=0. All synchronisers clear to 0.
- Debounce tick: free-running prescaler 0..CLK_FREQ_HZ/1000-1; tick on wrap.
- Per button:
  - 2-FF synchroniser, then inverted.
  - The counter clears whenever the synced level equals btn_out; otherwise it increments on each tick.
  - At DEBOUNCE_MS: btn_out takes the synced level and the counter clears.
  - A 0->1 change of btn_out pulses btn_press for one cycle.
- activity = (remote_event != remote_event_prev) | (|btn_press). remote_event_prev is registered every cycle.
- Idle counter:
  - Separate prescaler; activity clears both the prescaler and idle_ms.
  - Otherwise idle_ms increments once per ms and saturates.
- FSM, priority top-down:
  - bl_enable=0 -> OFF from any state.
  - OFF: bl_enable=1 -> ON.
  - ON: when timeout_ms!=0, idle_ms>=timeout_ms, force_on=0 and activity=0:
    - -> FADE with duty=2^PWM_W-1 if fade_step_ms!=0;
    - else -> DARK.
  - FADE or DARK: activity or force_on -> ON.
  - FADE: duty decrements by 1 every fade_step_ms ms. A fade-local ms counter starts at FADE entry. At duty==0 -> DARK.
- Drive:
  - ON: bl_pwm=1.
  - OFF, DARK: bl_pwm=0.
  - FADE: bl_pwm = (pwm_cnt < duty). pwm_cnt is a free-running PWM_W counter.
- timeout_ms and fade_step_ms are sampled live every cycle. Lowering timeout_ms below idle_ms in ON triggers the timeout on the next cycle.

## Timing
- Button: press accepted 2 sync cycles + DEBOUNCE_MS to DEBOUNCE_MS+1 ms after btn_in settles. btn_press coincides with the btn_out rise.
- remote_event edge -> activity 1 cycle after the synchronised edge -> idle_ms=0 and FSM to ON on the following cycle.
- All outputs are registered. bl_state and bl_pwm change one cycle after the condition.
- Simultaneous activity and timeout: activity wins, stays ON.
- Simultaneous bl_enable=0 and activity: OFF.
- Reset assertion mid-FADE: immediate OFF, bl_pwm=0.

## Configuration
- LCD_BL_FADE_EN defined:
  - FADE state and PWM logic present, as described above.
- LCD_BL_FADE_EN undefined:
  - FADE state, duty and pwm_cnt are removed; fade_step_ms is ignored.
  - ON -> DARK directly on timeout; bl_state never reads 10; bl_pwm is a pure level.

## Test plan
Bench parameters: CLK_FREQ_HZ=10000 (10 cycles/ms), PWM_W=2, DEBOUNCE_MS=3.
- Reset asserted mid-run -> all outputs 0, bl_state=00. After release, bl_enable=1 -> bl_state=01 and bl_pwm=1 within 2 cycles.
- timeout_ms=3, fade_step_ms=0, no activity -> DARK with bl_pwm=0 once idle_ms reaches 3 (30±2 cycles).
- timeout_ms=2, fade_step_ms=1 (macro defined):
  - FADE with duty 3, 2, 1, 0 at 10-cycle steps, then DARK;
  - at duty 2, bl_pwm is high exactly 2 of every 4 cycles;
  - with the macro undefined, the same stimulus goes straight to DARK.
- Toggle remote_event in DARK -> bl_state=01 within 3 cycles, idle_ms=0.
- btn_in[0]:
  - 2 ms low glitches -> btn_out=0, no pulse, no wake;
  - held low 5 ms -> btn_out[0]=1, single btn_press[0] pulse, idle_ms cleared.
- force_on=1 with idle_ms>timeout_ms -> stays ON. bl_enable=0 during FADE -> OFF and bl_pwm=0 next cycle.
